// File: rtl/e_mdu_ctrl_pkg.sv
// Shared pipeline constants: ALU ops, MDU ops and MDU FSM states.
// Imported by the MDU controller and its arithmetic sub-module.
package e_mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_e;

  localparam logic [31:0] MIN_INT = 32'h8000_0000;
  localparam logic [31:0] ALL_ONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/e_md_calc.sv
// Combinational mult/div datapath producing the full {HI,LO} result.
// Divide-by-zero and signed overflow are resolved explicitly here.
module e_md_calc
  import e_mdu_ctrl_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] rhi,
  output logic [31:0] rlo
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        ovf;

  assign prod_s = $signed({{32{a[31]}}, a})
                * $signed({{32{b[31]}}, b});
  assign prod_u = {32'b0, a} * {32'b0, b};
  assign ovf    = (a == MIN_INT) && (b == ALL_ONE);

  // Select the result pair for the requested operation
  always_comb begin
    rhi = '0;
    rlo = '0;
    case (op)
      MD_MULT:  {rhi, rlo} = prod_s;
      MD_MULTU: {rhi, rlo} = prod_u;
      MD_DIV: begin
        if (b == '0) begin
          rlo = ALL_ONE;
          rhi = a;
        end else if (ovf) begin
          rlo = MIN_INT;
          rhi = '0;
        end else begin
          rlo = $signed(a) / $signed(b);
          rhi = $signed(a) % $signed(b);
        end
      end
      MD_DIVU: begin
        if (b == '0) begin
          rlo = ALL_ONE;
          rhi = a;
        end else begin
          rlo = a / b;
          rhi = a % b;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu_ctrl.sv
// Multi-cycle MDU controller: IDLE/BUSY FSM, latency counter, HI/LO.
// Results are buffered at accept and committed on the final busy edge.
module e_mdu_ctrl
  import e_mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] HO
);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rhi_q, rhi_d;
  logic [31:0] rlo_q, rlo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] c_hi, c_lo;
  md_op_e      op;
  logic        is_mul, is_div;
  logic        is_mthi, is_mtlo;

  assign op      = md_op_e'(md_op);
  assign is_mul  = (op == MD_MULT) || (op == MD_MULTU);
  assign is_div  = (op == MD_DIV) || (op == MD_DIVU);
  assign is_mthi = (op == MD_MTHI);
  assign is_mtlo = (op == MD_MTLO);

  e_md_calc u_calc (
    .op  (op),
    .a   (A),
    .b   (B),
    .rhi (c_hi),
    .rlo (c_lo)
  );

  // Next-state: accept in IDLE, count down in BUSY, commit on cnt==1
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rhi_d   = rhi_q;
    rlo_d   = rlo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          unique case (1'b1)
            is_mul: begin
              state_d = S_BUSY;
              cnt_d   = 4'(MULT_CYCLES);
              rhi_d   = c_hi;
              rlo_d   = c_lo;
            end
            is_div: begin
              state_d = S_BUSY;
              cnt_d   = 4'(DIV_CYCLES);
              rhi_d   = c_hi;
              rlo_d   = c_lo;
            end
            is_mthi: hi_d = A;
            is_mtlo: lo_d = A;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          hi_d    = rhi_q;
          lo_d    = rlo_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and architectural registers, cleared by async reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rhi_q   <= '0;
      rlo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rhi_q   <= rhi_d;
      rlo_q   <= rlo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

  // Combinational read port for mfhi/mflo
  always_comb begin
    HO = '0;
    case (op)
      MD_MFHI: HO = hi_q;
      MD_MFLO: HO = lo_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Directed self-checking bench for e_mdu_ctrl.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_e_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  md_op;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] HO;

  int checks = 0;
  int errors = 0;

  e_mdu_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md_op (md_op),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO),
    .HO    (HO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one op at the current falling edge, measure busy length,
  // verify HI/LO stay frozen while busy, then check the committed result
  task automatic run_md(input string tag,
                        input logic [3:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int ncyc,
                        input logic [31:0] ehi,
                        input logic [31:0] elo);
    logic [31:0] hi0, lo0;
    logic        frozen;
    int          n;
    hi0    = HI;
    lo0    = LO;
    frozen = 1'b1;
    n      = 0;
    md_op  = op;
    start  = 1'b1;
    A      = a;
    B      = b;
    @(negedge clk);
    start = 1'b0;
    md_op = 4'd0;
    while (busy === 1'b1 && n < 40) begin
      if (HI !== hi0 || LO !== lo0) frozen = 1'b0;
      n++;
      @(negedge clk);
    end
    check({tag, "_cycles"}, 32'(n), 32'(ncyc));
    check({tag, "_frozen"}, {31'b0, frozen}, 32'd1);
    check({tag, "_hi"}, HI, ehi);
    check({tag, "_lo"}, LO, elo);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    start = 1'b0;
    md_op = 4'd0;
    A     = '0;
    B     = '0;
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);

    // first edge after release accepts mthi
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    md_op = 4'd7;
    A     = 32'h0000_0055;
    @(negedge clk);
    start = 1'b0;
    md_op = 4'd0;
    check("first_mthi", HI, 32'h0000_0055);
    check("first_busy", {31'b0, busy}, 32'd0);

    run_md("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 5,
           32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_md("divu", 4'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run_md("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10,
           32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5,
           32'd1, 32'hFFFF_FFFE);
    run_md("div0", 4'd3, 32'd5, 32'd0, 10,
           32'd5, 32'hFFFF_FFFF);
    run_md("divu0", 4'd4, 32'hABCD_0001, 32'd0, 10,
           32'hABCD_0001, 32'hFFFF_FFFF);
    run_md("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10,
           32'd0, 32'h8000_0000);

    // mthi during busy must be ignored
    md_op = 4'd2;
    start = 1'b1;
    A     = 32'h0001_0000;
    B     = 32'h0003_0000;
    @(negedge clk);
    start = 1'b0;
    md_op = 4'd0;
    @(negedge clk);
    md_op = 4'd7;
    start = 1'b1;
    A     = 32'd9;
    @(negedge clk);
    start = 1'b0;
    md_op = 4'd0;
    check("mid_hi_held", HI, 32'd0);
    check("mid_busy", {31'b0, busy}, 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("mid_hi", HI, 32'd3);
    check("mid_lo", LO, 32'd0);

    // mtlo in the completion cycle must be ignored
    md_op = 4'd1;
    start = 1'b1;
    A     = 32'd4;
    B     = 32'd5;
    @(negedge clk);
    start = 1'b0;
    md_op = 4'd0;
    repeat (4) @(negedge clk);
    check("cmp_last_busy", {31'b0, busy}, 32'd1);
    md_op = 4'd8;
    start = 1'b1;
    A     = 32'h0000_00AA;
    @(negedge clk);
    start = 1'b0;
    md_op = 4'd0;
    check("cmp_busy", {31'b0, busy}, 32'd0);
    check("cmp_lo", LO, 32'd20);
    @(negedge clk);
    check("cmp_lo_after", LO, 32'd20);

    // move and read path
    md_op = 4'd8;
    start = 1'b1;
    A     = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_lo", LO, 32'h1234_5678);
    check("mtlo_busy", {31'b0, busy}, 32'd0);
    md_op = 4'd6;
    #1;
    check("mflo_ho", HO, 32'h1234_5678);
    md_op = 4'd5;
    #1;
    check("mfhi_ho", HO, 32'd0);
    md_op = 4'd0;
    #1;
    check("none_ho", HO, 32'd0);
    md_op = 4'd12;
    #1;
    check("op12_ho", HO, 32'd0);
    md_op = 4'd0;

    // start with op 12 acts as none
    @(negedge clk);
    md_op = 4'd12;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    md_op = 4'd0;
    check("op12_busy", {31'b0, busy}, 32'd0);

    // reset in the middle of a div
    md_op = 4'd7;
    start = 1'b1;
    A     = 32'h0000_0077;
    @(negedge clk);
    md_op = 4'd4;
    A     = 32'd100;
    B     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    md_op = 4'd0;
    check("pre_rst_hi", HI, 32'h0000_0077);
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_hi", HI, 32'd0);
    check("arst_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_busy", {31'b0, busy}, 32'd0);
    check("post_rst_hi", HI, 32'd0);
    check("post_rst_lo", LO, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
